systolic_matmul_top: RTL and testbench

- Parametrised N×N matrix-multiply top: C = A·B.
- Captures A and B on a valid/ready handshake, feeds skewed rows and columns into an N×N output-stationary PE grid, and counts cycles to completion.
- Presents the registered C with valid/ready backpressure.
- Successor to the fixed 4×4/8-bit top; adds width, depth, signedness and overflow-mode generality plus input/output flow control.

---
 rtl/systolic_pkg.sv | 40 ++++
 rtl/systolic_matmul_top_pe.sv | 56 +++++
 rtl/systolic_matmul_top.sv | 128 ++++++++++++
 tb/tb_systolic_matmul_top.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic matrix-multiply block.
// Holds the FSM state type, latency/width helpers and the MAC adder.
package systolic_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic int latency(input int n);
    return 3 * n - 1;
  endfunction

  function automatic int acc_w_default(input int dw, input int n);
    return 2 * dw + $clog2(n);
  endfunction

  // Operands arrive already extended to 64 bits; caller truncates to w.
  function automatic logic [63:0] sat_add(
    input logic [63:0] acc,
    input logic [63:0] prod,
    input int          w,
    input bit          sgn,
    input bit          sat
  );
    logic [63:0] sum;
    logic [63:0] hi;
    logic [63:0] lo;
    sum = acc + prod;
    if (!sat) return sum;
    if (sgn) begin
      hi = (64'd1 << (w - 1)) - 64'd1;
      lo = ~hi;
      if ($signed(sum) > $signed(hi)) return hi;
      if ($signed(sum) < $signed(lo)) return lo;
      return sum;
    end
    hi = (64'd1 << w) - 64'd1;
    if (sum > hi) return hi;
    return sum;
  endfunction

endpackage

// File: rtl/systolic_matmul_top_pe.sv
// One output-stationary MAC cell of the systolic grid.
// Forwards a right and b down through registers.
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 18,
  parameter int SIGNED   = 0,
  parameter int SATURATE = 0
) (
  input  logic              i_clk,
  input  logic              i_arst,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic              clr,
  input  logic              en,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic [ACC_W-1:0]  acc
);

  localparam int PW = 2 * DATA_W;

  logic signed [PW-1:0] ps;
  logic [PW-1:0]        pu;
  logic [PW-1:0]        prod;
  logic [63:0]          pext;
  logic [63:0]          aext;
  logic [DATA_W-1:0]    a_q;
  logic [DATA_W-1:0]    b_q;
  logic [ACC_W-1:0]     acc_q;

  assign ps   = PW'($signed(a_in)) * PW'($signed(b_in));
  assign pu   = PW'(a_in) * PW'(b_in);
  assign prod = (SIGNED != 0) ? ps : pu;
  assign pext = {{(64-PW){(SIGNED != 0) && prod[PW-1]}}, prod};
  assign aext = {{(64-ACC_W){(SIGNED != 0) && acc_q[ACC_W-1]}}, acc_q};

  always_ff @(posedge i_clk) begin
    if (i_arst || clr) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else if (en) begin
      a_q   <= a_in;
      b_q   <= b_in;
      acc_q <= ACC_W'(sat_add(aext, pext, ACC_W,
                              SIGNED != 0, SATURATE != 0));
    end
  end

  assign a_out = a_q;
  assign b_out = b_q;
  assign acc   = acc_q;

endmodule

// File: rtl/systolic_matmul_top.sv
// N x N systolic matrix multiply C = A*B with valid/ready on both sides.
// Skewed row/column feeds drive an output-stationary PE grid.
module systolic_matmul_top
  import systolic_pkg::*;
#(
  parameter int N        = 4,
  parameter int DATA_W   = 8,
  parameter int ACC_W    = acc_w_default(DATA_W, N),
  parameter int SIGNED   = 0,
  parameter int SATURATE = 0
) (
  input  logic                               i_clk,
  input  logic                               i_arst,
  input  logic [N-1:0][N-1:0][DATA_W-1:0]    i_a,
  input  logic [N-1:0][N-1:0][DATA_W-1:0]    i_b,
  input  logic                               i_validInput,
  output logic                               o_readyInput,
  output logic [N-1:0][N-1:0][ACC_W-1:0]     o_c,
  output logic                               o_validResult,
  input  logic                               i_readyResult
);

  localparam int             CW   = $clog2(3 * N);
  // Accumulators settle one edge after the last MAC.
  localparam logic [CW-1:0]  LAST = CW'(latency(N) - 1);

  state_t                            st_q;
  logic [CW-1:0]                     cnt_q;
  logic                              rdy_q;
  logic                              vld_q;
  logic [N-1:0][N-1:0][ACC_W-1:0]    c_q;
  logic [N-1:0][N-1:0][DATA_W-1:0]   asr_q;
  logic [N-1:0][N-1:0][DATA_W-1:0]   bsr_q;
  logic [N-1:0][N-1:0][ACC_W-1:0]    acc_g;
  logic [DATA_W-1:0]                 a_h [N][N+1];
  logic [DATA_W-1:0]                 b_v [N+1][N];
  logic [DATA_W-1:0]                 a_unused [N];
  logic [DATA_W-1:0]                 b_unused [N];
  logic                              go;
  logic                              en;

  assign go = (st_q == IDLE) && i_validInput;
  assign en = (st_q == RUN);

  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      st_q  <= IDLE;
      cnt_q <= '0;
      rdy_q <= 1'b1;
      vld_q <= 1'b0;
      c_q   <= '0;
    end else begin
      unique case (st_q)
        IDLE: if (i_validInput) begin
          st_q  <= RUN;
          cnt_q <= '0;
          rdy_q <= 1'b0;
        end
        RUN: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            st_q  <= DONE;
            vld_q <= 1'b1;
            c_q   <= acc_g;
          end
        end
        DONE: if (i_readyResult) begin
          st_q  <= IDLE;
          vld_q <= 1'b0;
          rdy_q <= 1'b1;
        end
        default: st_q <= IDLE;
      endcase
    end
  end

  // Row r / column r start shifting once the step reaches r.
  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      asr_q <= '0;
      bsr_q <= '0;
    end else if (go) begin
      asr_q <= i_a;
      for (int r = 0; r < N; r++)
        for (int k = 0; k < N; k++)
          bsr_q[r][k] <= i_b[k][r];
    end else if (en) begin
      for (int r = 0; r < N; r++)
        if (cnt_q >= CW'(r)) begin
          asr_q[r] <= asr_q[r] >> DATA_W;
          bsr_q[r] <= bsr_q[r] >> DATA_W;
        end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_feed
    assign a_h[i][0] = (cnt_q >= CW'(i)) ? asr_q[i][0] : '0;
    assign b_v[0][i] = (cnt_q >= CW'(i)) ? bsr_q[i][0] : '0;
    assign a_unused[i] = a_h[i][N];
    assign b_unused[i] = b_v[N][i];
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      systolic_pe #(
        .DATA_W  (DATA_W),
        .ACC_W   (ACC_W),
        .SIGNED  (SIGNED),
        .SATURATE(SATURATE)
      ) u_pe (
        .i_clk (i_clk),
        .i_arst(i_arst),
        .a_in  (a_h[i][j]),
        .b_in  (b_v[i][j]),
        .clr   (go),
        .en    (en),
        .a_out (a_h[i][j+1]),
        .b_out (b_v[i+1][j]),
        .acc   (acc_g[i][j])
      );
    end
  end

  assign o_readyInput  = rdy_q;
  assign o_validResult = vld_q;
  assign o_c           = c_q;

endmodule

// File: tb/tb_systolic_matmul_top.sv
// Directed bench for systolic_matmul_top across width/sign/saturation variants.
// Five instances share stimulus; each has its own expected results.
module tb_systolic_matmul_top;

  logic i_clk = 1'b0;
  logic i_arst = 1'b1;
  logic vld = 1'b0;
  logic rdy = 1'b0;
  logic [3:0][3:0][7:0] ma;
  logic [3:0][3:0][7:0] mb;

  logic [3:0][3:0][17:0] c0;
  logic [3:0][3:0][15:0] c1;
  logic [3:0][3:0][15:0] c2;
  logic [3:0][3:0][17:0] c3;
  logic [3:0][3:0][15:0] c4;
  logic [4:0] rin;
  logic [4:0] vout;

  int tests = 0;
  int fails = 0;

  always #5 i_clk = ~i_clk;

  systolic_matmul_top u_def (
    .i_clk(i_clk), .i_arst(i_arst), .i_a(ma), .i_b(mb),
    .i_validInput(vld), .o_readyInput(rin[0]), .o_c(c0),
    .o_validResult(vout[0]), .i_readyResult(rdy));

  systolic_matmul_top #(.ACC_W(16), .SATURATE(1)) u_s16 (
    .i_clk(i_clk), .i_arst(i_arst), .i_a(ma), .i_b(mb),
    .i_validInput(vld), .o_readyInput(rin[1]), .o_c(c1),
    .o_validResult(vout[1]), .i_readyResult(rdy));

  systolic_matmul_top #(.ACC_W(16), .SATURATE(0)) u_w16 (
    .i_clk(i_clk), .i_arst(i_arst), .i_a(ma), .i_b(mb),
    .i_validInput(vld), .o_readyInput(rin[2]), .o_c(c2),
    .o_validResult(vout[2]), .i_readyResult(rdy));

  systolic_matmul_top #(.SIGNED(1)) u_sgn (
    .i_clk(i_clk), .i_arst(i_arst), .i_a(ma), .i_b(mb),
    .i_validInput(vld), .o_readyInput(rin[3]), .o_c(c3),
    .o_validResult(vout[3]), .i_readyResult(rdy));

  systolic_matmul_top #(.ACC_W(16), .SIGNED(1), .SATURATE(1)) u_ss (
    .i_clk(i_clk), .i_arst(i_arst), .i_a(ma), .i_b(mb),
    .i_validInput(vld), .o_readyInput(rin[4]), .o_c(c4),
    .o_validResult(vout[4]), .i_readyResult(rdy));

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic set_ident_b();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        ma[i][j] = (i == j) ? 8'd1 : 8'd0;
        mb[i][j] = 8'(4 * i + j);
      end
  endtask

  task automatic set_fill(input logic [7:0] av, input logic [7:0] bv);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        ma[i][j] = av;
        mb[i][j] = bv;
      end
  endtask

  task automatic run_op(output int lat);
    @(negedge i_clk);
    vld = 1'b1;
    @(posedge i_clk);
    #1;
    vld = 1'b0;
    chk("busy", {31'd0, rin[0]}, 32'd0);
    lat = 0;
    while (!vout[0] && lat < 40) begin
      @(posedge i_clk);
      #1;
      lat++;
    end
  endtask

  task automatic release_res();
    @(negedge i_clk);
    rdy = 1'b1;
    @(posedge i_clk);
    #1;
    rdy = 1'b0;
  endtask

  // ident=1: C must equal B (4i+j); otherwise each instance has a fill value.
  task automatic check_all(input string tag, input bit ident,
                           input int e0, input int e1, input int e2,
                           input int e3, input int e4);
    int ev;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        ev = 4 * i + j;
        chk($sformatf("%s def c%0d%0d", tag, i, j), 32'(c0[i][j]),
            ident ? ev : (e0 & 32'h3ffff));
        chk($sformatf("%s s16 c%0d%0d", tag, i, j), 32'(c1[i][j]),
            ident ? ev : (e1 & 32'hffff));
        chk($sformatf("%s w16 c%0d%0d", tag, i, j), 32'(c2[i][j]),
            ident ? ev : (e2 & 32'hffff));
        chk($sformatf("%s sgn c%0d%0d", tag, i, j), 32'(c3[i][j]),
            ident ? ev : (e3 & 32'h3ffff));
        chk($sformatf("%s ss c%0d%0d", tag, i, j), 32'(c4[i][j]),
            ident ? ev : (e4 & 32'hffff));
      end
    chk({tag, " vld all"}, {27'd0, vout}, 32'h1f);
  endtask

  initial begin
    int lat;
    ma = '0;
    mb = '0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_arst = 1'b0;
    #1;
    chk("rst rdy", {31'd0, rin[0]}, 32'd1);
    chk("rst vld", {31'd0, vout[0]}, 32'd0);
    chk("rst c", {31'd0, c0 == '0}, 32'd1);

    set_ident_b();
    run_op(lat);
    chk("lat ident", lat, 32'd11);
    check_all("ident", 1'b1, 0, 0, 0, 0, 0);
    release_res();
    chk("idle rdy", {31'd0, rin[0]}, 32'd1);

    set_fill(8'd255, 8'd255);
    run_op(lat);
    chk("lat 255", lat, 32'd11);
    check_all("ff", 1'b0, 260100, 65535, 63492, 4, 4);
    release_res();

    set_fill(8'h80, 8'h7f);
    run_op(lat);
    check_all("sgn", 1'b0, 65024, 65024, 65024, -65024, -32768);

    // Hold the result and poke a new request that must be ignored.
    for (int k = 0; k < 20; k++) begin
      @(negedge i_clk);
      if (k == 5) begin
        set_ident_b();
        vld = 1'b1;
      end
      if (k == 8) vld = 1'b0;
      @(posedge i_clk);
      #1;
      chk("hold c", 32'(c0[3][3]), 32'd65024);
      chk("hold rdy", {31'd0, rin[0]}, 32'd0);
      chk("hold vld", {31'd0, vout[0]}, 32'd1);
    end
    chk("hold sgn c", 32'(c3[1][2]), 32'h3ffff & (-65024));
    release_res();
    chk("rel rdy", {31'd0, rin[0]}, 32'd1);
    set_ident_b();
    run_op(lat);
    check_all("after", 1'b1, 0, 0, 0, 0, 0);
    release_res();

    // Abort a multiply at counter step 5.
    set_fill(8'd255, 8'd255);
    @(negedge i_clk);
    vld = 1'b1;
    @(posedge i_clk);
    #1;
    vld = 1'b0;
    repeat (5) @(posedge i_clk);
    @(negedge i_clk);
    i_arst = 1'b1;
    @(posedge i_clk);
    #1;
    chk("abort rdy", {31'd0, rin[0]}, 32'd1);
    chk("abort vld", {31'd0, vout[0]}, 32'd0);
    chk("abort c", {31'd0, c0 == '0}, 32'd1);
    @(negedge i_clk);
    i_arst = 1'b0;
    set_ident_b();
    run_op(lat);
    chk("lat abort", lat, 32'd11);
    check_all("post", 1'b1, 0, 0, 0, 0, 0);
    release_res();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
